// File: rtl/pp_st0_dec.sv
// Decoder-side stage-0 ping-pong buffer.
// Packs re/im sample pairs into wide rows and writes whole frames into two
// buffers in turn. Each completed frame is read back in row order through a
// small credit-controlled output FIFO with a valid/ready handshake.
module pp_st0_dec #(
  parameter int IN_DATA_WIDTH  = 64,
  parameter int OUT_DATA_WIDTH = 512,
  parameter int FRAME_ROWS     = 1024,
  parameter int LATENCY        = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [IN_DATA_WIDTH-1:0]  in_re,
  input  logic [IN_DATA_WIDTH-1:0]  in_im,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_DATA_WIDTH-1:0] out_data,
  output logic                      out_last,
  output logic                      fill_sel,
  output logic                      drain_sel
);

  localparam int PAIRS  = OUT_DATA_WIDTH / (2 * IN_DATA_WIDTH);
  localparam int AW     = (FRAME_ROWS > 1) ? $clog2(FRAME_ROWS) : 1;
  localparam int PW     = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam int FDEPTH = LATENCY + 2;
  localparam int CW     = $clog2(FDEPTH + 1);
  localparam int FPW    = $clog2(FDEPTH);

  typedef enum logic [1:0] {
    BUF_EMPTY,
    BUF_FILLING,
    BUF_FULL,
    BUF_DRAINING
  } buf_state_e;

  buf_state_e                state_q [2];
  buf_state_e                state_d [2];
  logic                      fill_sel_q, fill_sel_d;
  logic                      drain_sel_q, drain_sel_d;
  logic [PW-1:0]             pcnt_q, pcnt_d;
  logic [AW-1:0]             wcnt_q, wcnt_d;
  logic [AW-1:0]             rcnt_q, rcnt_d;
  logic [CW-1:0]             credit_q, credit_d;
  logic [LATENCY-1:0]        pipe_vld_q, pipe_vld_d;
  logic [LATENCY-1:0]        pipe_last_q, pipe_last_d;
  logic [FPW-1:0]            fifo_wp_q, fifo_wp_d;
  logic [FPW-1:0]            fifo_rp_q, fifo_rp_d;
  logic [CW-1:0]             fifo_cnt_q, fifo_cnt_d;
  logic [OUT_DATA_WIDTH-1:0] row_q, row_d;

  logic [OUT_DATA_WIDTH-1:0] ram_q       [2][FRAME_ROWS];
  logic [OUT_DATA_WIDTH-1:0] pipe_data_q [LATENCY];
  logic [OUT_DATA_WIDTH-1:0] fifo_data_q [FDEPTH];
  logic                      fifo_last_q [FDEPTH];

  logic accept, row_done, frame_done;
  logic can_read, issue, read_last, push, pop;

  assign in_ready   = !rst && (state_q[fill_sel_q] == BUF_EMPTY ||
                               state_q[fill_sel_q] == BUF_FILLING);
  assign accept     = in_valid && in_ready;
  assign row_done   = accept && (pcnt_q == PW'(PAIRS - 1));
  assign frame_done = row_done && (wcnt_q == AW'(FRAME_ROWS - 1));

  assign can_read  = state_q[drain_sel_q] == BUF_FULL ||
                     state_q[drain_sel_q] == BUF_DRAINING;
  assign out_valid = !rst && (fifo_cnt_q != '0);
  assign pop       = out_valid && out_ready;
  // Credits cover reads in flight plus FIFO entries, so the FIFO never overflows.
  assign issue     = !rst && can_read && ((credit_q - CW'(pop)) < CW'(FDEPTH));
  assign read_last = issue && (rcnt_q == AW'(FRAME_ROWS - 1));
  assign push      = pipe_vld_q[LATENCY-1];

  assign out_data  = fifo_data_q[fifo_rp_q];
  assign out_last  = out_valid && fifo_last_q[fifo_rp_q];
  assign fill_sel  = fill_sel_q;
  assign drain_sel = drain_sel_q;

  // Drop the accepted pair into its lane of the row under assembly.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    row_d = row_q;
    for (int p = 0; p < PAIRS; p++) begin
      if (accept && pcnt_q == PW'(p)) begin
        row_d[2*p*IN_DATA_WIDTH +: IN_DATA_WIDTH]     = in_re;
        row_d[(2*p+1)*IN_DATA_WIDTH +: IN_DATA_WIDTH] = in_im;
      end
    end
  end

  // Buffer life cycle, fill/drain counters and buffer selects.
  always_comb begin
    state_d[0]  = state_q[0];
    state_d[1]  = state_q[1];
    fill_sel_d  = fill_sel_q;
    drain_sel_d = drain_sel_q;
    pcnt_d      = pcnt_q;
    wcnt_d      = wcnt_q;
    rcnt_d      = rcnt_q;
    if (accept) begin
      pcnt_d = row_done ? '0 : pcnt_q + PW'(1);
      if (state_q[fill_sel_q] == BUF_EMPTY) state_d[fill_sel_q] = BUF_FILLING;
    end
    if (row_done) wcnt_d = frame_done ? '0 : wcnt_q + AW'(1);
    if (frame_done) begin
      state_d[fill_sel_q] = BUF_FULL;
      fill_sel_d          = ~fill_sel_q;
    end
    // The fill and drain buffers never coincide while both are active, so
    // these updates cannot collide on one state entry.
    if (issue) begin
      rcnt_d = read_last ? '0 : rcnt_q + AW'(1);
      if (read_last) begin
        state_d[drain_sel_q] = BUF_EMPTY;
        drain_sel_d          = ~drain_sel_q;
      end else begin
        state_d[drain_sel_q] = BUF_DRAINING;
      end
    end
  end

  // Read pipeline tags, credit counter and FIFO pointers.
  always_comb begin
    pipe_vld_d     = pipe_vld_q;
    pipe_last_d    = pipe_last_q;
    pipe_vld_d[0]  = issue;
    pipe_last_d[0] = read_last;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_last_d[i] = pipe_last_q[i-1];
    end
    credit_d   = credit_q + CW'(issue) - CW'(pop);
    fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
    fifo_wp_d  = fifo_wp_q;
    fifo_rp_d  = fifo_rp_q;
    if (push) fifo_wp_d = (fifo_wp_q == FPW'(FDEPTH - 1)) ? '0 : fifo_wp_q + FPW'(1);
    if (pop)  fifo_rp_d = (fifo_rp_q == FPW'(FDEPTH - 1)) ? '0 : fifo_rp_q + FPW'(1);
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q[0]  <= BUF_EMPTY;
      state_q[1]  <= BUF_EMPTY;
      fill_sel_q  <= 1'b0;
      drain_sel_q <= 1'b0;
      pcnt_q      <= '0;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      credit_q    <= '0;
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
      fifo_wp_q   <= '0;
      fifo_rp_q   <= '0;
      fifo_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      fill_sel_q  <= fill_sel_d;
      drain_sel_q <= drain_sel_d;
      pcnt_q      <= pcnt_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      credit_q    <= credit_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_last_q <= pipe_last_d;
      fifo_wp_q   <= fifo_wp_d;
      fifo_rp_q   <= fifo_rp_d;
      fifo_cnt_q  <= fifo_cnt_d;
    end
  end

  // Datapath storage: row assembly, frame RAMs, read pipeline, FIFO entries.
  always_ff @(posedge clk) begin
    // NOTE: storage arrays carry no reset; their contents only matter once the reset control flops mark them valid.
    row_q <= row_d;
    if (row_done) ram_q[fill_sel_q][wcnt_q] <= row_d;
    if (issue) pipe_data_q[0] <= ram_q[drain_sel_q][rcnt_q];
    for (int i = 1; i < LATENCY; i++) pipe_data_q[i] <= pipe_data_q[i-1];
    if (push) begin
      fifo_data_q[fifo_wp_q] <= pipe_data_q[LATENCY-1];
      fifo_last_q[fifo_wp_q] <= pipe_last_q[LATENCY-1];
    end
  end

endmodule

// File: tb/tb_pp_st0_dec.sv
// Directed bench for pp_st0_dec: FRAME_ROWS=4, PAIRS=4, LATENCY=1.
// A packing model feeds an in-order scoreboard checked by an output monitor.
module tb_pp_st0_dec;

  localparam int IW    = 16;
  localparam int OW    = 128;
  localparam int FR    = 4;
  localparam int LAT   = 1;
  localparam int PAIRS = OW / (2 * IW);
  localparam int BEATS = FR * PAIRS;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_re;
  logic [IW-1:0] in_im;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          out_last;
  logic          fill_sel;
  logic          drain_sel;

  always #5 clk = ~clk;

  pp_st0_dec #(
    .IN_DATA_WIDTH (IW),
    .OUT_DATA_WIDTH(OW),
    .FRAME_ROWS    (FR),
    .LATENCY       (LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_re    (in_re),
    .in_im    (in_im),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .fill_sel (fill_sel),
    .drain_sel(drain_sel)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // out_ready driver: 0 = low, 1 = high, 2 = repeating 1,0,0,1.
  int ready_mode = 0;
  int bp_idx     = 0;
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: begin
        out_ready = (bp_idx == 0) || (bp_idx == 3);
        bp_idx    = (bp_idx + 1) % 4;
      end
    endcase
  end

  // Expected rows in output order.
  logic [OW-1:0] exp_data_q [$];
  logic          exp_last_q [$];
  logic [OW-1:0] m_row = '0;
  int            m_pair = 0;
  int            m_rowidx = 0;

  task automatic model_beat(input logic [IW-1:0] re, input logic [IW-1:0] im);
    m_row[2*m_pair*IW +: IW]     = re;
    m_row[(2*m_pair+1)*IW +: IW] = im;
    if (m_pair == PAIRS - 1) begin
      exp_data_q.push_back(m_row);
      exp_last_q.push_back(m_rowidx == FR - 1);
      m_rowidx = (m_rowidx + 1) % FR;
      m_pair   = 0;
    end else begin
      m_pair++;
    end
  endtask

  task automatic model_clear();
    exp_data_q.delete();
    exp_last_q.delete();
    m_pair   = 0;
    m_rowidx = 0;
  endtask

  // Output monitor: in-order data/last, stall stability, FIFO occupancy.
  logic          stall_q = 1'b0;
  logic [OW-1:0] held = '0;
  int            max_occ = 0;
  int            n_rx = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (int'(dut.fifo_cnt_q) > max_occ) max_occ = int'(dut.fifo_cnt_q);
      if (stall_q && out_valid) check("hold_stable", out_data, held);
      if (out_valid && out_ready) begin
        if (exp_data_q.size() == 0) begin
          check("extra_row", 1'b1, 1'b0);
        end else begin
          check("row_data", out_data, exp_data_q.pop_front());
          check("row_last", out_last, exp_last_q.pop_front());
        end
        n_rx++;
      end
      stall_q = out_valid && !out_ready;
      held    = out_data;
    end else begin
      stall_q = 1'b0;
    end
  end

  // Called at posedge+1; returns at the next posedge+1 after acceptance.
  task automatic send_beat(input logic [IW-1:0] re, input logic [IW-1:0] im, output int waited);
    waited   = 0;
    in_valid = 1'b1;
    in_re    = re;
    in_im    = im;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (in_ready) model_beat(re, im);
    else check("in_ready_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_beats(input int f, input int n, output int stalls);
    int w;
    stalls = 0;
    for (int k = 0; k < n; k++) begin
      send_beat(IW'(f * 4096 + k), IW'(f * 4096 + 256 + k), w);
      stalls += w;
    end
  endtask

  task automatic wait_drain(input int max_cyc);
    int c = 0;
    while (exp_data_q.size() != 0 && c < max_cyc) begin
      @(negedge clk);
      c++;
    end
    check("drain_done", exp_data_q.size() == 0, 1'b1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int            st;
    logic [OW-1:0] row0_exp;
    row0_exp = {16'h0103, 16'h0003, 16'h0102, 16'h0002,
                16'h0101, 16'h0001, 16'h0100, 16'h0000};
    rst      = 1'b1;
    in_valid = 1'b0;
    in_re    = '0;
    in_im    = '0;

    // T1: reset holds the handshake outputs low.
    repeat (3) begin
      @(negedge clk);
      check("t1_rst_in_ready", in_ready, 1'b0);
      check("t1_rst_out_valid", out_valid, 1'b0);
      check("t1_rst_out_last", out_last, 1'b0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("t1_in_ready", in_ready, 1'b1);
    check("t1_fill_sel", fill_sel, 1'b0);
    check("t1_drain_sel", drain_sel, 1'b0);
    check("t1_out_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;

    // T2: single frame, latency and lane order of row 0.
    ready_mode = 1;
    n_rx = 0;
    send_beats(0, BEATS, st);
    check("t2_no_stall", st, 0);
    @(negedge clk);
    check("t2_lat_c1", out_valid, 1'b0);
    @(negedge clk);
    check("t2_lat_c2", out_valid, 1'b0);
    @(negedge clk);
    check("t2_lat_c3", out_valid, 1'b1);
    check("t2_row0", out_data, row0_exp);
    check("t2_row0_last", out_last, 1'b0);
    @(posedge clk);
    #1;
    wait_drain(50);
    check("t2_rows", n_rx, 4);

    // T3: three frames with the output blocked.
    ready_mode = 0;
    n_rx = 0;
    send_beats(1, BEATS, st);
    send_beats(2, BEATS, st);
    check("t3_no_stall_f12", st, 0);
    @(negedge clk);
    check("t3_in_ready_low", in_ready, 1'b0);
    check("t3_out_valid_held", out_valid, 1'b1);
    repeat (5) @(negedge clk);
    check("t3_in_ready_still_low", in_ready, 1'b0);
    @(posedge clk);
    #1;
    ready_mode = 1;
    send_beats(3, BEATS, st);
    wait_drain(200);
    check("t3_rows", n_rx, 12);

    // T4: output backpressure pattern 1,0,0,1.
    ready_mode = 2;
    n_rx = 0;
    send_beats(4, BEATS, st);
    wait_drain(200);
    check("t4_rows", n_rx, 4);
    check("t4_fifo_occ_le3", max_occ <= 3, 1'b1);

    // T5: frame B streams in while frame A drains.
    ready_mode = 1;
    n_rx = 0;
    send_beats(5, BEATS, st);
    check("t5_no_stall_a", st, 0);
    send_beats(6, BEATS, st);
    check("t5_no_stall_b", st, 0);
    wait_drain(100);
    check("t5_rows", n_rx, 8);

    // T6: reset mid-fill and mid-drain, then a fresh frame.
    ready_mode = 0;
    send_beats(7, BEATS, st);
    send_beats(8, 7, st);
    @(negedge clk);
    check("t6_pre_out_valid", out_valid, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_clear();
    @(negedge clk);
    check("t6_rst_out_valid", out_valid, 1'b0);
    check("t6_rst_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_post_out_valid", out_valid, 1'b0);
    check("t6_post_fill_sel", fill_sel, 1'b0);
    check("t6_post_drain_sel", drain_sel, 1'b0);
    check("t6_post_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    ready_mode = 1;
    n_rx = 0;
    send_beats(9, BEATS, st);
    wait_drain(100);
    check("t6_rows", n_rx, 4);
    check("t6_fill_sel_after", fill_sel, 1'b1);
    check("t6_drain_sel_after", drain_sel, 1'b1);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
